// File: rtl/l2_track_pkg.sv
// Shared definitions for the L2 pipeline commit tracker.
// Holds the FSM state type, default parameter values and a multi-hot helper.
package l2_track_pkg;

  localparam int unsigned DEF_NUM_STAGES = 4;
  localparam int unsigned DEF_MAX_CYCLES = 50;
  localparam int unsigned DEF_CNT_SAT    = 132;
  localparam int unsigned MAX_STAGES     = 8;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StArmed    = 3'd1,
    StInflight = 3'd2,
    StDone     = 3'd3,
    StTimeout  = 3'd4
  } l2_state_e;

  // True when more than one bit of vec is set.
  function automatic logic f_multi_hot(input logic [MAX_STAGES-1:0] vec);
    return (vec & (vec - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/l2_track_stage.sv
// One token-holding pipeline stage register.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   i_load     : token leaving the upstream stage this cycle
//   i_stall    : this stage is stalled, hold contents
//   i_block    : downstream stage is stalled, keep our own token in place
//   o_token    : token-present flag
module l2_track_stage (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_stall,
  input  logic i_block,
  output logic o_token
);

  logic r_token;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_token <= 1'b0;
    end else if (!i_stall) begin
      // A token that cannot be accepted downstream stays here instead of vanishing.
      r_token <= i_load | (r_token & i_block);
    end
  end

  assign o_token = r_token;

endmodule

// File: rtl/l2_pipe_commit_tracker.sv
// Tracks a single token through an L2 pipeline from arm to commit.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   start_i      : arm request (honoured only in idle)
//   valid_s1_i   : stage-1 valid, launches the token while armed
//   stall_i      : per-stage stall, bit 0 = S1
//   token_o      : per-stage token-present flags (bit 0 combinational)
//   commit_o     : one-cycle commit pulse
//   cycle_cnt_o  : saturating cycles since arm
//   state_o      : FSM state
//   ended_o, late_o, timeout_o, proto_err_o : sticky status flags
module l2_pipe_commit_tracker
  import l2_track_pkg::*;
#(
  parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
  parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned CNT_SAT    = DEF_CNT_SAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  valid_s1_i,
  input  logic [NUM_STAGES-1:0] stall_i,
  output logic [NUM_STAGES-1:0] token_o,
  output logic                  commit_o,
  output logic [CNT_W-1:0]      cycle_cnt_o,
  output logic [2:0]            state_o,
  output logic                  ended_o,
  output logic                  late_o,
  output logic                  timeout_o,
  output logic                  proto_err_o
);

  localparam logic [CNT_W-1:0] LP_SAT = CNT_W'(CNT_SAT);

  l2_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_commit;
  logic             r_ended;
  logic             r_late;
  logic             r_timeout;
  logic             r_proto;

  logic                  w_tok0;
  logic [NUM_STAGES-1:1] w_stage;
  logic [NUM_STAGES-1:1] w_block;
  logic [NUM_STAGES-1:0] w_tok;
  logic [NUM_STAGES-1:0] w_leave;
  logic                  w_launch;
  logic                  w_at_sat;
  logic                  w_proto;

  // Gated by rst_n so no token is visible while reset is asserted.
  assign w_tok0   = rst_n & (r_state == StArmed) & valid_s1_i & ~stall_i[0];
  assign w_tok    = {w_stage, w_tok0};
  assign w_leave  = w_tok & ~stall_i;
  // The S1 token is only accepted when S2 can take it; otherwise we stay armed.
  assign w_launch = w_tok0 & ~stall_i[1];
  assign w_at_sat = (r_cnt == LP_SAT);
  assign w_proto  = (|(w_leave[NUM_STAGES-2:0] & stall_i[NUM_STAGES-1:1]))
                  | f_multi_hot(MAX_STAGES'(w_tok));

  for (genvar k = 1; k < NUM_STAGES; k++) begin : g_stage
    if (k < NUM_STAGES - 1) begin : g_mid
      assign w_block[k] = stall_i[k+1];
    end else begin : g_last
      assign w_block[k] = 1'b0;
    end

    l2_track_stage u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_leave[k-1]),
      .i_stall (stall_i[k]),
      .i_block (w_block[k]),
      .o_token (w_stage[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_commit  <= 1'b0;
      r_ended   <= 1'b0;
      r_late    <= 1'b0;
      r_timeout <= 1'b0;
      r_proto   <= 1'b0;
    end else begin
      // Only a token exiting the last stage during flight counts as a commit.
      r_commit <= w_leave[NUM_STAGES-1] & (r_state == StInflight);
      if (w_proto) begin
        r_proto <= 1'b1;
      end
      case (r_state)
        StIdle: begin
          if (start_i) begin
            r_state <= StArmed;
          end
        end
        StArmed: begin
          if (!w_at_sat) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_at_sat) begin
            r_state   <= StTimeout;
            r_timeout <= 1'b1;
          end else if (w_launch) begin
            r_state <= StInflight;
          end
        end
        StInflight: begin
          if (!w_at_sat) begin
            r_cnt <= r_cnt + 1'b1;
          end
          // Commit wins over timeout when both land on the same cycle.
          if (r_commit) begin
            r_state <= StDone;
            if (32'(r_cnt) <= MAX_CYCLES) begin
              r_ended <= 1'b1;
            end else begin
              r_late <= 1'b1;
            end
          end else if (w_at_sat) begin
            r_state   <= StTimeout;
            r_timeout <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign token_o     = w_tok;
  assign commit_o    = r_commit;
  assign cycle_cnt_o = r_cnt;
  assign state_o     = r_state;
  assign ended_o     = r_ended;
  assign late_o      = r_late;
  assign timeout_o   = r_timeout;
  assign proto_err_o = r_proto;

endmodule

// File: tb/tb_l2_pipe_commit_tracker.sv
module tb_l2_pipe_commit_tracker;
  import l2_track_pkg::*;

  localparam int N    = 4;
  localparam int MAXC = 50;
  localparam int CW   = 8;
  localparam int SAT  = 132;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          valid_s1_i = 1'b0;
  logic [N-1:0]  stall_i = '0;
  logic [N-1:0]  token_o;
  logic          commit_o;
  logic [CW-1:0] cycle_cnt_o;
  logic [2:0]    state_o;
  logic          ended_o, late_o, timeout_o, proto_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  l2_pipe_commit_tracker #(
    .NUM_STAGES (N),
    .MAX_CYCLES (MAXC),
    .CNT_W      (CW),
    .CNT_SAT    (SAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .valid_s1_i  (valid_s1_i),
    .stall_i     (stall_i),
    .token_o     (token_o),
    .commit_o    (commit_o),
    .cycle_cnt_o (cycle_cnt_o),
    .state_o     (state_o),
    .ended_o     (ended_o),
    .late_o      (late_o),
    .timeout_o   (timeout_o),
    .proto_err_o (proto_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: token position (-1 = none in registered stages), phase, counter, flags.
  l2_state_e m_ph;
  int        m_pos;
  int        m_cnt;
  bit        m_commit, m_ended, m_late, m_to, m_proto;

  task automatic model_reset();
    m_ph = StIdle; m_pos = -1; m_cnt = 0;
    m_commit = 0; m_ended = 0; m_late = 0; m_to = 0; m_proto = 0;
  endtask

  function automatic logic [N-1:0] exp_tokens();
    logic [N-1:0] t;
    t = '0;
    if (rst_n && m_ph == StArmed && valid_s1_i && !stall_i[0]) t[0] = 1'b1;
    if (m_pos >= 1) t[m_pos] = 1'b1;
    return t;
  endfunction

  task automatic model_check();
    chk("token", 32'(token_o), 32'(exp_tokens()));
    chk("commit", 32'(commit_o), 32'(m_commit));
    chk("cnt", 32'(cycle_cnt_o), 32'(m_cnt));
    chk("state", 32'(state_o), 32'(m_ph));
    chk("ended", 32'(ended_o), 32'(m_ended));
    chk("late", 32'(late_o), 32'(m_late));
    chk("timeout", 32'(timeout_o), 32'(m_to));
    chk("proto", 32'(proto_err_o), 32'(m_proto));
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [N-1:0] t;
    int p, p_next;
    bit new_commit;
    l2_state_e ph_n;
    t = exp_tokens();
    p = t[0] ? 0 : m_pos;
    p_next = m_pos;
    new_commit = 0;
    ph_n = m_ph;
    if (p >= 0 && !stall_i[p]) begin
      if (p == N - 1) begin
        new_commit = (m_ph == StInflight);
        p_next = -1;
      end else if (stall_i[p+1]) begin
        m_proto = 1;
      end else begin
        p_next = p + 1;
      end
    end
    case (m_ph)
      StIdle: if (start_i) ph_n = StArmed;
      StArmed: begin
        if (m_cnt == SAT) begin ph_n = StTimeout; m_to = 1; end
        else if (p == 0 && p_next == 1) ph_n = StInflight;
      end
      StInflight: begin
        if (m_commit) begin
          ph_n = StDone;
          if (m_cnt <= MAXC) m_ended = 1; else m_late = 1;
        end else if (m_cnt == SAT) begin
          ph_n = StTimeout; m_to = 1;
        end
      end
      default: ;
    endcase
    if ((m_ph == StArmed || m_ph == StInflight) && m_cnt < SAT) m_cnt++;
    m_ph = ph_n;
    m_pos = p_next;
    m_commit = new_commit;
  endtask

  // Inputs change at posedge+1; outputs are checked at the following negedge.
  task automatic apply(input logic st, input logic v, input logic [N-1:0] sl);
    start_i = st; valid_s1_i = v; stall_i = sl;
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start_i = 1'b0; valid_s1_i = 1'b0; stall_i = '0;
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  // Run with valid high and no stalls until a terminal state, bounded.
  task automatic run_to_end(input string name, input int budget);
    bit reached;
    reached = 0;
    for (int i = 0; i < budget && !reached; i++) begin
      apply(1'b0, 1'b1, '0);
      if (state_o == StDone || state_o == StTimeout) reached = 1;
      advance();
    end
    chk(name, 32'(reached), 32'd1);
  endtask

  typedef struct {
    logic         st;
    logic         v;
    logic [N-1:0] sl;
    logic [N-1:0] tok;
    logic         cm;
    int           cnt;
    l2_state_e    ph;
    logic [3:0]   flags;  // {ended, late, timeout, proto}
  } vec_t;

  vec_t t_clean[$];
  vec_t t_stall[$];

  task automatic run_vec(input string name, input vec_t e);
    apply(e.st, e.v, e.sl);
    chk({name, "_tok"}, 32'(token_o), 32'(e.tok));
    chk({name, "_commit"}, 32'(commit_o), 32'(e.cm));
    chk({name, "_cnt"}, 32'(cycle_cnt_o), 32'(e.cnt));
    chk({name, "_state"}, 32'(state_o), 32'(e.ph));
    chk({name, "_flags"}, 32'({ended_o, late_o, timeout_o, proto_err_o}), 32'(e.flags));
    advance();
  endtask

  initial begin
    bit seen_commit;
    int vp;

    t_clean.push_back('{1, 1, 4'b0000, 4'b0000, 0, 0, StIdle,     4'b0000});
    t_clean.push_back('{0, 1, 4'b0000, 4'b0001, 0, 0, StArmed,    4'b0000});
    t_clean.push_back('{0, 1, 4'b0000, 4'b0010, 0, 1, StInflight, 4'b0000});
    t_clean.push_back('{0, 1, 4'b0000, 4'b0100, 0, 2, StInflight, 4'b0000});
    t_clean.push_back('{0, 1, 4'b0000, 4'b1000, 0, 3, StInflight, 4'b0000});
    t_clean.push_back('{0, 1, 4'b0000, 4'b0000, 1, 4, StInflight, 4'b0000});
    t_clean.push_back('{0, 1, 4'b0000, 4'b0000, 0, 5, StDone,     4'b1000});
    t_clean.push_back('{1, 1, 4'b0000, 4'b0000, 0, 5, StDone,     4'b1000});

    t_stall.push_back('{1, 1, 4'b0000, 4'b0000, 0, 0, StIdle,     4'b0000});
    t_stall.push_back('{0, 1, 4'b0000, 4'b0001, 0, 0, StArmed,    4'b0000});
    t_stall.push_back('{0, 1, 4'b0000, 4'b0010, 0, 1, StInflight, 4'b0000});
    t_stall.push_back('{0, 1, 4'b0100, 4'b0100, 0, 2, StInflight, 4'b0000});
    t_stall.push_back('{0, 1, 4'b0100, 4'b0100, 0, 3, StInflight, 4'b0000});
    t_stall.push_back('{0, 1, 4'b0100, 4'b0100, 0, 4, StInflight, 4'b0000});
    t_stall.push_back('{0, 1, 4'b0000, 4'b0100, 0, 5, StInflight, 4'b0000});
    t_stall.push_back('{0, 1, 4'b0000, 4'b1000, 0, 6, StInflight, 4'b0000});
    t_stall.push_back('{0, 1, 4'b0000, 4'b0000, 1, 7, StInflight, 4'b0000});
    t_stall.push_back('{0, 1, 4'b0000, 4'b0000, 0, 8, StDone,     4'b1000});

    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    chk("reset_state", 32'(state_o), 32'(StIdle));
    chk("reset_outputs", 32'({token_o, commit_o, cycle_cnt_o, ended_o, late_o, timeout_o,
                              proto_err_o}), 32'd0);
    @(posedge clk);
    #1;

    foreach (t_clean[i]) run_vec("clean", t_clean[i]);

    do_reset();
    foreach (t_stall[i]) run_vec("stall_s3", t_stall[i]);

    // Late commit after a long wait for valid.
    do_reset();
    apply(1'b1, 1'b0, '0); advance();
    for (int i = 0; i < 60; i++) begin apply(1'b0, 1'b0, '0); advance(); end
    run_to_end("late_bound", 20);
    @(negedge clk);
    chk("late_flag", 32'(late_o), 32'd1);
    chk("late_ended", 32'(ended_o), 32'd0);
    @(posedge clk); #1;

    // Timeout with valid never asserted.
    do_reset();
    seen_commit = 0;
    apply(1'b1, 1'b0, '0); advance();
    for (int i = 0; i < 140; i++) begin
      apply(1'b0, 1'b0, '0);
      if (commit_o) seen_commit = 1;
      advance();
    end
    @(negedge clk);
    chk("to_flag", 32'(timeout_o), 32'd1);
    chk("to_cnt", 32'(cycle_cnt_o), 32'(SAT));
    chk("to_state", 32'(state_o), 32'(StTimeout));
    chk("to_no_commit", 32'(seen_commit), 32'd0);
    @(posedge clk); #1;

    // Protocol error: S3 stalled as the token leaves S2.
    do_reset();
    apply(1'b1, 1'b1, '0); advance();
    apply(1'b0, 1'b1, '0); advance();
    apply(1'b0, 1'b1, 4'b0100); advance();
    apply(1'b0, 1'b1, '0);
    chk("proto_flag", 32'(proto_err_o), 32'd1);
    chk("proto_held", 32'(token_o), 32'h2);
    advance();
    run_to_end("proto_bound", 20);
    @(negedge clk);
    chk("proto_ended", 32'(ended_o), 32'd1);
    @(posedge clk); #1;

    // Reset asserted while armed with valid high: S1 token must stay low.
    do_reset();
    apply(1'b1, 1'b1, '0); advance();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_tok0", 32'(token_o[0]), 32'd0);
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;

    // Reset mid-flight with the token in S2, then a normal run.
    apply(1'b1, 1'b1, '0); advance();
    apply(1'b0, 1'b1, '0); advance();
    apply(1'b0, 1'b1, '0);
    chk("mid_tok_s2", 32'(token_o), 32'h2);
    rst_n = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
    seen_commit = 0;
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, '0);
      if (commit_o) seen_commit = 1;
      advance();
    end
    chk("mid_no_commit", 32'(seen_commit), 32'd0);
    apply(1'b1, 1'b1, '0); advance();
    run_to_end("mid_bound", 20);
    @(negedge clk);
    chk("mid_ended", 32'(ended_o), 32'd1);
    @(posedge clk); #1;

    // Randomised runs against the model.
    for (int r = 0; r < 20; r++) begin
      do_reset();
      vp = $urandom_range(0, 9);
      for (int c = 0; c < 150; c++) begin
        logic [N-1:0] sl;
        for (int b = 0; b < N; b++) sl[b] = ($urandom_range(0, 5) == 0);
        apply(($urandom_range(0, 3) == 0) || c == 0, $urandom_range(0, 9) < vp, sl);
        advance();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
